// File: rtl/gf_dot_32_pkg.sv
// Shared GF(2^32) definitions: field width, reduction polynomial,
// multiplier latency and the dot-product sequencer state encoding.
package gf_dot_32_pkg;

  localparam int GF32_W = 32;

  // x^32 + x^22 + x^2 + x + 1, low 32 bits
  localparam logic [GF32_W-1:0] GF32_POLY = 32'h0040_0007;

  localparam int GF_MUL_LAT = 4;
  localparam int GF_DOT_MUL_LAT_DEF = 8;

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } dot_state_e;

  function automatic logic [2*GF32_W-2:0] gf32_clmul(
    input logic [GF32_W-1:0] a,
    input logic [GF32_W-1:0] b
  );
    logic [2*GF32_W-2:0] acc;
    acc = '0;
    for (int i = 0; i < GF32_W; i++) begin
      if (b[i]) acc = acc ^ ({{(GF32_W-1){1'b0}}, a} << i);
    end
    return acc;
  endfunction

  function automatic logic [GF32_W-1:0] gf32_reduce(
    input logic [2*GF32_W-2:0] c
  );
    logic [2*GF32_W-2:0] r;
    logic [2*GF32_W-2:0] p;
    r = c;
    p = {{(GF32_W-2){1'b0}}, 1'b1, GF32_POLY};
    for (int i = 2*GF32_W-2; i >= GF32_W; i--) begin
      if (r[i]) r = r ^ (p << (i - GF32_W));
    end
    return r[GF32_W-1:0];
  endfunction

endpackage

// File: rtl/gf_dot_32_mul.sv
// gf_mul_32: 4-stage pipelined GF(2^32) multiplier, one op per cycle.
// No reset: the valid chain can carry stale tokens after power-up.
module gf_mul_32
  import gf_dot_32_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_start,
  input  logic [GF32_W-1:0] i_a,
  input  logic [GF32_W-1:0] i_b,
  output logic [GF32_W-1:0] o_p,
  output logic              o_done
);

  logic                v1_q, v2_q, v3_q, v4_q;
  logic [GF32_W-1:0]   a1_q, b1_q;
  logic [2*GF32_W-2:0] c2_q;
  logic [GF32_W-1:0]   r3_q, p4_q;

  always_ff @(posedge i_clk) begin
    v1_q <= i_start;
    a1_q <= i_a;
    b1_q <= i_b;
    v2_q <= v1_q;
    c2_q <= gf32_clmul(a1_q, b1_q);
    v3_q <= v2_q;
    r3_q <= gf32_reduce(c2_q);
    v4_q <= v3_q;
    p4_q <= r3_q;
  end

  assign o_p    = p4_q;
  assign o_done = v4_q;

endmodule

// File: rtl/gf_dot_32.sv
// GF(2^32) inner-product sequencer: streams operand RAM pairs into
// gf_mul_32 and XOR-accumulates. GF_DOT_32_ACC_INIT_EN adds i_acc_init.
module gf_dot_32
  import gf_dot_32_pkg::*;
#(
  parameter int N_TERMS = 16,
  parameter int ADDR_W  = 4,
  parameter int MUL_LAT = GF_DOT_MUL_LAT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_ready,
  output logic              o_busy,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_addr,
  input  logic [GF32_W-1:0] i_x,
  input  logic [GF32_W-1:0] i_y,
`ifdef GF_DOT_32_ACC_INIT_EN
  input  logic [GF32_W-1:0] i_acc_init,
`endif
  output logic [GF32_W-1:0] o_z,
  output logic              o_done
);

  localparam int RW = $clog2(N_TERMS + 1);
  localparam int FW = $clog2(MUL_LAT + 3);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_TERMS - 1);
  localparam logic [RW-1:0]     RET_LAST   = RW'(N_TERMS - 1);
  localparam logic [FW-1:0]     FLUSH_LAST = FW'(MUL_LAT + 1);

  dot_state_e        state_q, state_d;
  logic [ADDR_W-1:0] iss_q, iss_d;
  logic [RW-1:0]     ret_q, ret_d;
  logic [FW-1:0]     fl_q, fl_d;
  logic [GF32_W-1:0] acc_q, acc_d;
  logic [GF32_W-1:0] z_q, z_d;
  logic              mstart_q;
  logic [GF32_W-1:0] mul_p;
  logic              mul_done;
  logic [GF32_W-1:0] seed;
  logic              acc_hit;

`ifdef GF_DOT_32_ACC_INIT_EN
  assign seed = i_acc_init;
`else
  assign seed = '0;
`endif

  gf_mul_32 u_mul (
    .i_clk   (i_clk),
    .i_start (mstart_q),
    .i_a     (i_x),
    .i_b     (i_y),
    .o_p     (mul_p),
    .o_done  (mul_done)
  );

  // Products only count while a run is live; flush/idle drop stale tokens
  assign acc_hit = mul_done &&
                   (state_q == ST_ISSUE || state_q == ST_DRAIN);

  always_comb begin
    state_d = state_q;
    iss_d   = iss_q;
    ret_d   = ret_q;
    fl_d    = fl_q;
    acc_d   = acc_q;
    z_d     = z_q;
    if (acc_hit) begin
      acc_d = acc_q ^ mul_p;
      ret_d = ret_q + RW'(1);
    end
    unique case (state_q)
      ST_FLUSH: begin
        fl_d = fl_q + FW'(1);
        if (fl_q == FLUSH_LAST) begin
          fl_d    = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (i_start) begin
          acc_d   = seed;
          iss_d   = '0;
          ret_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (iss_q == LAST_ADDR) state_d = ST_DRAIN;
        else                    iss_d   = iss_q + ADDR_W'(1);
      end
      ST_DRAIN: begin
        if (acc_hit && ret_q == RET_LAST) begin
          z_d     = acc_d;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_FLUSH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_FLUSH;
      iss_q    <= '0;
      ret_q    <= '0;
      fl_q     <= '0;
      acc_q    <= '0;
      z_q      <= '0;
      mstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      iss_q    <= iss_d;
      ret_q    <= ret_d;
      fl_q     <= fl_d;
      acc_q    <= acc_d;
      z_q      <= z_d;
      mstart_q <= o_rd_en;
    end
  end

  assign o_ready = (state_q == ST_IDLE);
  assign o_rd_en = (state_q == ST_ISSUE);
  assign o_busy  = (state_q == ST_ISSUE) || (state_q == ST_DRAIN) ||
                   (state_q == ST_DONE);
  assign o_done  = (state_q == ST_DONE);
  assign o_addr  = iss_q;
  assign o_z     = z_q;

endmodule
